// File: rtl/mont_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mont_pkg : shared types and sizing helpers for the digit-serial Montgomery blocks
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
package mont_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFTING = 2'd1,
      DONE     = 2'd2
   } sreg_state_t;

   // Smallest counter that must still hold the value NDIG itself, not just NDIG-1.
   localparam int MIN_CNT_W = 1;

   function automatic int ndigits(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_width(input int ndig);
      return ($clog2(ndig + 1) < MIN_CNT_W) ? MIN_CNT_W : $clog2(ndig + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mont_digit_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mont_digit_cnt : loadable down-counter of remaining digits
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module mont_digit_cnt #(
   parameter int CNT_W    = 3,
   parameter int LOAD_VAL = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             clear,
   input  logic             load,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero_next
);

   // Flags the decrement that consumes the final digit.
   assign zero_next = dec && (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rstb) begin
         cnt <= '0;
      end else if (ena) begin
         if (clear) begin
            cnt <= '0;
         end else if (load) begin
            cnt <= CNT_W'(LOAD_VAL);
         end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mont_operand_sreg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mont_operand_sreg : digit-serial operand shift register, LSB digit first
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module mont_operand_sreg
   import mont_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             clear,
   input  logic             ld_r,
   input  logic             lock,
   input  logic             shift,
   input  logic [WIDTH-1:0] reg_rji,
   input  logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] R_i,
   output logic [DIGIT-1:0] digit_o,
   output logic             busy,
   output logic             last,
   output logic             done
);

   localparam int NDIG  = ndigits(WIDTH, DIGIT);
   localparam int CNT_W = cnt_width(NDIG);

   if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $fatal(1, "mont_operand_sreg: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   sreg_state_t      state, state_d;
   logic [WIDTH-1:0] r_d;
   logic [CNT_W-1:0] cnt;
   logic             dec;
   logic             zero_next;

   assign dec = shift && (state == SHIFTING);

   mont_digit_cnt #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (NDIG)
   ) u_cnt (
      .clk       (clk),
      .rstb      (rstb),
      .ena       (ena),
      .clear     (clear),
      .load      (ld_r),
      .dec       (dec),
      .cnt       (cnt),
      .zero_next (zero_next)
   );

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state <= IDLE;
         R_i   <= '0;
      end else if (ena) begin
         state <= state_d;
         R_i   <= r_d;
      end
   end

   // Load outranks shift, so a simultaneous shift never touches the new operand.
   always_comb begin
      state_d = state;
      r_d     = R_i;
      if (clear) begin
         state_d = IDLE;
         r_d     = '0;
      end else if (ld_r) begin
         state_d = SHIFTING;
         r_d     = lock ? reg_rji : A;
      end else if (dec) begin
         r_d = R_i >> DIGIT;
         if (zero_next) begin
            state_d = DONE;
         end
      end
   end

   assign digit_o = R_i[DIGIT-1:0];
   assign busy    = (state == SHIFTING);
   assign done    = (state == DONE);
   assign last    = busy && (cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: tb/tb_mont_operand_sreg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mont_operand_sreg : directed bench for mont_operand_sreg, WIDTH=8 DIGIT=2
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_mont_operand_sreg;

   logic       clk = 1'b0;
   logic       rstb, ena, clear, ld_r, lock, shift;
   logic [7:0] reg_rji, A;
   logic [7:0] R_i;
   logic [1:0] digit_o;
   logic       busy, last, done;

   int compared   = 0;
   int mismatched = 0;

   mont_operand_sreg #(.WIDTH(8), .DIGIT(2)) dut (
      .clk     (clk),
      .rstb    (rstb),
      .ena     (ena),
      .clear   (clear),
      .ld_r    (ld_r),
      .lock    (lock),
      .shift   (shift),
      .reg_rji (reg_rji),
      .A       (A),
      .R_i     (R_i),
      .digit_o (digit_o),
      .busy    (busy),
      .last    (last),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [7:0] val);
      lock = 1'b0; A = val; ld_r = 1'b1; shift = 1'b0;
      tick();
      ld_r = 1'b0;
   endtask

   task automatic test_reset();
      rstb = 1'b0; ena = 1'b1; clear = 1'b0; ld_r = 1'b0; lock = 1'b0; shift = 1'b0;
      reg_rji = 8'h00; A = 8'h00;
      tick(); tick();
      compared++; if (R_i !== 8'h00) begin mismatched++; $display("FAIL reset_R_i got=%h exp=00", R_i); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
      compared++; if (last !== 1'b0) begin mismatched++; $display("FAIL reset_last got=%b exp=0", last); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got=%b exp=0", done); end
      compared++; if (digit_o !== 2'd0) begin mismatched++; $display("FAIL reset_digit got=%0d exp=0", digit_o); end
      rstb = 1'b1;
   endtask

   task automatic test_shift_sequence();
      logic [1:0] exp_dig  [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
      logic       exp_last [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      load_a(8'hB4);
      compared++; if (R_i !== 8'hB4) begin mismatched++; $display("FAIL seq_load_R_i got=%h exp=b4", R_i); end
      compared++; if (dut.cnt !== 3'd4) begin mismatched++; $display("FAIL seq_load_cnt got=%0d exp=4", dut.cnt); end
      for (int i = 0; i < 4; i++) begin
         compared++; if (digit_o !== exp_dig[i]) begin mismatched++; $display("FAIL seq_digit%0d got=%0d exp=%0d", i, digit_o, exp_dig[i]); end
         compared++; if (last !== exp_last[i]) begin mismatched++; $display("FAIL seq_last%0d got=%b exp=%b", i, last, exp_last[i]); end
         compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL seq_early_done%0d got=%b exp=0", i, done); end
         shift = 1'b1;
         tick();
      end
      shift = 1'b0;
      compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL seq_done got=%b exp=1", done); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL seq_busy_end got=%b exp=0", busy); end
      compared++; if (R_i !== 8'h00) begin mismatched++; $display("FAIL seq_residue got=%h exp=00", R_i); end
      compared++; if (digit_o !== 2'd0) begin mismatched++; $display("FAIL seq_done_digit got=%0d exp=0", digit_o); end
   endtask

   task automatic test_lock_load();
      lock = 1'b1; reg_rji = 8'h5A; A = 8'hFF; ld_r = 1'b1;
      tick();
      ld_r = 1'b0; lock = 1'b0;
      compared++; if (R_i !== 8'h5A) begin mismatched++; $display("FAIL lock_R_i got=%h exp=5a", R_i); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL lock_busy got=%b exp=1", busy); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL lock_done got=%b exp=0", done); end
      compared++; if (dut.cnt !== 3'd4) begin mismatched++; $display("FAIL lock_cnt got=%0d exp=4", dut.cnt); end
      compared++; if (digit_o !== 2'd2) begin mismatched++; $display("FAIL lock_digit got=%0d exp=2", digit_o); end
   endtask

   task automatic test_load_shift_collision();
      load_a(8'hB4);
      shift = 1'b1;
      tick();
      compared++; if (R_i !== 8'h2D) begin mismatched++; $display("FAIL coll_pre_R_i got=%h exp=2d", R_i); end
      compared++; if (dut.cnt !== 3'd3) begin mismatched++; $display("FAIL coll_pre_cnt got=%0d exp=3", dut.cnt); end
      A = 8'h0F; ld_r = 1'b1; shift = 1'b1;
      tick();
      ld_r = 1'b0; shift = 1'b0;
      compared++; if (R_i !== 8'h0F) begin mismatched++; $display("FAIL coll_R_i got=%h exp=0f", R_i); end
      compared++; if (dut.cnt !== 3'd4) begin mismatched++; $display("FAIL coll_cnt got=%0d exp=4", dut.cnt); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL coll_busy got=%b exp=1", busy); end
   endtask

   task automatic test_ena_hold();
      load_a(8'hB4);
      shift = 1'b1;
      tick(); tick();
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++; if (R_i !== 8'h0B) begin mismatched++; $display("FAIL hold_R_i%0d got=%h exp=0b", i, R_i); end
         compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL hold_busy%0d got=%b exp=1", i, busy); end
         compared++; if (dut.cnt !== 3'd2) begin mismatched++; $display("FAIL hold_cnt%0d got=%0d exp=2", i, dut.cnt); end
      end
      compared++; if (digit_o !== 2'd3) begin mismatched++; $display("FAIL hold_digit got=%0d exp=3", digit_o); end
      ena = 1'b1;
      tick();
      compared++; if (R_i !== 8'h02) begin mismatched++; $display("FAIL resume_R_i got=%h exp=02", R_i); end
      compared++; if (last !== 1'b1) begin mismatched++; $display("FAIL resume_last got=%b exp=1", last); end
      tick();
      shift = 1'b0;
      compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL resume_done got=%b exp=1", done); end
      compared++; if (digit_o !== 2'd0) begin mismatched++; $display("FAIL resume_digit got=%0d exp=0", digit_o); end
   endtask

   task automatic test_done_shift_clear();
      shift = 1'b1;
      tick();
      shift = 1'b0;
      compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL dshift_done got=%b exp=1", done); end
      compared++; if (R_i !== 8'h00) begin mismatched++; $display("FAIL dshift_R_i got=%h exp=00", R_i); end
      compared++; if (dut.cnt !== 3'd0) begin mismatched++; $display("FAIL dshift_cnt got=%0d exp=0", dut.cnt); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL clear_done got=%b exp=0", done); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL clear_busy got=%b exp=0", busy); end
      compared++; if (R_i !== 8'h00) begin mismatched++; $display("FAIL clear_R_i got=%h exp=00", R_i); end
      // Clear outranks a simultaneous load.
      lock = 1'b0; A = 8'hC3; ld_r = 1'b1; clear = 1'b1;
      tick();
      ld_r = 1'b0; clear = 1'b0;
      compared++; if (R_i !== 8'h00) begin mismatched++; $display("FAIL clrld_R_i got=%h exp=00", R_i); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL clrld_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_midop();
      load_a(8'hB4);
      shift = 1'b1;
      tick();
      rstb = 1'b0; ld_r = 1'b1; shift = 1'b1; A = 8'hB4;
      tick();
      compared++; if (R_i !== 8'h00) begin mismatched++; $display("FAIL rmid_R_i got=%h exp=00", R_i); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      compared++; if (last !== 1'b0) begin mismatched++; $display("FAIL rmid_last got=%b exp=0", last); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rmid_done got=%b exp=0", done); end
      compared++; if (digit_o !== 2'd0) begin mismatched++; $display("FAIL rmid_digit got=%0d exp=0", digit_o); end
      compared++; if (dut.cnt !== 3'd0) begin mismatched++; $display("FAIL rmid_cnt got=%0d exp=0", dut.cnt); end
      rstb = 1'b1; ld_r = 1'b0; shift = 1'b0;
   endtask

   initial begin
      test_reset();
      test_shift_sequence();
      test_lock_load();
      test_load_shift_collision();
      test_ena_hold();
      test_done_shift_clear();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
